// File: rtl/bank_joltage.sv
// Streams decimal digits per bank, tracks the best ordered two-digit pair,
// and queues one result per bank through a small FIFO.
module bank_joltage #(
  parameter int RES_WIDTH  = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_digit,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [RES_WIDTH-1:0] out_data,
  output logic                 out_err,
  output logic [CNT_WIDTH-1:0] bank_count
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, SCAN} state_e;

  state_e         state_q, state_d;
  logic [3:0]     mf_q, mf_d;
  logic [6:0]     best_q, best_d;
  logic           err_q, err_d;
  // pair_q: a second legal digit has followed the first one
  logic           pair_q, pair_d;
  logic [6:0]     cand, res;
  logic           legal, acc, push, pop, res_err, full, empty;
  logic [AW:0]    wr_q, rd_q;
  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [CNT_WIDTH-1:0] cnt_q;

  assign legal = (in_digit <= 4'd9);
  assign acc   = in_valid && in_ready;
  assign push  = acc && in_last;
  assign pop   = out_valid && out_ready;
  assign cand  = 7'(mf_q) * 7'd10 + 7'(in_digit);

  always_comb begin
    state_d = state_q;
    mf_d    = mf_q;
    best_d  = best_q;
    err_d   = err_q;
    pair_d  = pair_q;
    res     = '0;
    res_err = 1'b0;
    if (acc) begin
      if (!legal) begin
        err_d = 1'b1;
      end else if (state_q == IDLE) begin
        mf_d    = in_digit;
        state_d = SCAN;
      end else begin
        if (cand > best_q)    best_d = cand;
        if (in_digit > mf_q)  mf_d   = in_digit;
        pair_d = 1'b1;
      end
      if (in_last) begin
        res     = pair_d ? best_d : 7'd0;
        res_err = err_d | ~pair_d;
        state_d = IDLE;
        mf_d    = '0;
        best_d  = '0;
        err_d   = 1'b0;
        pair_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mf_q    <= '0;
      best_q  <= '0;
      err_q   <= 1'b0;
      pair_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mf_q    <= mf_d;
      best_q  <= best_d;
      err_q   <= err_d;
      pair_q  <= pair_d;
      if (push) begin
        wr_q  <= wr_q + 1'b1;
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
      if (pop) rd_q <= rd_q + 1'b1;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= {res_err, res};
  end

  assign empty      = (wr_q == rd_q);
  assign full       = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign in_ready   = !full;
  assign out_valid  = !empty;
  assign out_data   = out_valid ? RES_WIDTH'(mem_q[rd_q[AW-1:0]][6:0]) : '0;
  assign out_err    = out_valid && mem_q[rd_q[AW-1:0]][7];
  assign bank_count = cnt_q;
endmodule

// File: tb/tb_bank_joltage.sv
// Directed bench for bank_joltage: hand-computed bank results, backpressure,
// malformed banks and mid-bank reset.
module tb_bank_joltage;
  localparam int RW = 32;
  localparam int CW = 16;
  localparam int FD = 2;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [3:0]    in_digit = 4'd0;
  logic          in_ready, out_valid, out_err;
  logic [RW-1:0] out_data;
  logic [CW-1:0] bank_count;

  int checks = 0, failures = 0, sum = 0;
  logic [RW:0] popq[$];

  always #5 clk = ~clk;

  bank_joltage #(.RES_WIDTH(RW), .CNT_WIDTH(CW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_digit(in_digit), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .bank_count(bank_count)
  );

  // Outputs are stable mid-cycle; a handshake seen here completes at the next edge.
  always @(negedge clk)
    if (rst_n && out_valid && out_ready) popq.push_back({out_err, out_data});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1; in_digit = d; in_last = l;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) chk("send_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_bank(input string s);
    for (int i = 0; i < s.len(); i++) begin
      logic [7:0] c;
      logic [3:0] d;
      c = s[i];
      d = (c >= 8'h41) ? 4'(c - 8'h37) : 4'(c - 8'h30);
      send(d, i == s.len() - 1);
    end
  endtask

  task automatic expect_pop(input string tag, input logic [31:0] d, input logic e);
    int n = 0;
    logic [RW:0] v;
    while (popq.size() == 0 && n < 100) begin @(posedge clk); #1; n++; end
    if (popq.size() == 0) chk({tag, "_timeout"}, 32'(popq.size()), 32'd1);
    else begin
      v = popq.pop_front();
      chk({tag, "_data"}, v[RW-1:0], d);
      chk({tag, "_err"}, 32'(v[RW]), 32'(e));
      sum += int'(v[RW-1:0]);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_bank_count", 32'(bank_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single bank, latency 1
    out_ready = 1'b1;
    send_bank("987654321111111");
    chk("b98_valid", 32'(out_valid), 32'd1);
    chk("b98_data", out_data, 32'd98);
    chk("b98_err", 32'(out_err), 32'd0);
    expect_pop("b98", 32'd98, 1'b0);
    chk("b98_count", 32'(bank_count), 32'd1);

    // Back-to-back banks and downstream sum
    do_reset();
    sum = 0;
    send_bank("811111111111119");
    send_bank("234234234234278");
    send_bank("818181911112111");
    expect_pop("b89", 32'd89, 1'b0);
    expect_pop("b78", 32'd78, 1'b0);
    expect_pop("b92", 32'd92, 1'b0);
    chk("three_count", 32'(bank_count), 32'd3);
    send_bank("987654321111111");
    expect_pop("b98b", 32'd98, 1'b0);
    chk("sum357", 32'(sum), 32'd357);
    chk("four_count", 32'(bank_count), 32'd4);

    // Backpressure: FIFO fills, blocked beats are ignored, nothing lost
    out_ready = 1'b0;
    send_bank("12");
    send_bank("34");
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(bank_count), 32'd6);
    chk("full_head", out_data, 32'd12);
    in_valid = 1'b1; in_digit = 4'd9; in_last = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    in_valid = 1'b0; in_last = 1'b0;
    chk("blocked_count", 32'(bank_count), 32'd6);
    chk("stall_head", out_data, 32'd12);
    chk("stall_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    send_bank("56");
    expect_pop("bp12", 32'd12, 1'b0);
    expect_pop("bp34", 32'd34, 1'b0);
    expect_pop("bp56", 32'd56, 1'b0);
    chk("bp_count", 32'(bank_count), 32'd7);

    // Simultaneous push and pop with FIFO_DEPTH-1 entries held
    out_ready = 1'b0;
    send_bank("78");
    send(4'd1, 1'b0);
    out_ready = 1'b1;
    send(4'd9, 1'b1);
    chk("pp_valid", 32'(out_valid), 32'd1);
    chk("pp_head", out_data, 32'd19);
    expect_pop("pp78", 32'd78, 1'b0);
    expect_pop("pp19", 32'd19, 1'b0);
    chk("pp_count", 32'(bank_count), 32'd9);

    // Malformed banks and the 0,0 corner
    send_bank("7A3");
    expect_pop("bad73", 32'd73, 1'b1);
    send_bank("5");
    expect_pop("single5", 32'd0, 1'b1);
    send_bank("00");
    expect_pop("zero_pair", 32'd0, 1'b0);
    send_bank("A5");
    expect_pop("bad_one_legal", 32'd0, 1'b1);

    // Reset mid-bank discards the partial bank
    send(4'd9, 1'b0);
    send(4'd9, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_count", 32'(bank_count), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_bank("12");
    expect_pop("post_rst12", 32'd12, 1'b0);
    chk("post_rst_count", 32'(bank_count), 32'd1);
    repeat (5) begin @(posedge clk); #1; end
    chk("post_rst_no_extra", 32'(popq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
